// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-2 deep buffer of {pc, instr} pairs with flush
// Ports: push/push_data write, pop/pop_data read head, flush empties,
// count/full/empty report occupancy. Push at full is accepted only with a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic          do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    count = cnt_q;
    pop_data = mem_q[rd_q];
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and instruction fetch front end with a small fetch buffer
// Ports: redirect/redirect_pc take a branch target; imem_* is a single-outstanding
// request/grant/response memory port; if_* presents the buffer head to decode
// over valid/ready. Optional FETCH_PERF_EN adds perf_fetched/perf_discarded/perf_stall.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d, addr_q, addr_d;
  logic          granted, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_data('{pc: addr_q, instr: imem_rdata}),
    .pop      (pop),
    .pop_data (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= REQ;
    else state_q <= state_d;
  end
  // A redirect that coincides with a grant leaves that fetch in flight, so it must be drained
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = granted ? (redirect ? DISCARD : WAIT) : REQ;
      WAIT:    state_d = imem_rvalid ? REQ : (redirect ? DISCARD : WAIT);
      DISCARD: state_d = imem_rvalid ? REQ : DISCARD;
      default: state_d = REQ;
    endcase
  end
  // A pop this cycle frees a slot, so a request may issue even when the buffer is full
  always_comb begin
    if_valid = ~empty;
    pop = if_valid & if_ready;
    imem_req = rst_n & (state_q == REQ) & ((count < CW'(BUF_DEPTH)) | pop);
    imem_addr = pc_q;
    granted = imem_req & imem_gnt;
    push = (state_q == WAIT) & imem_rvalid & ~redirect & (~full | pop);
    if_pc = if_valid ? head.pc : '0;
    if_pc_plus4 = if_valid ? head.pc + INSTR_BYTES : '0;
    if_instr = if_valid ? head.instr : '0;
    pc_d = redirect ? (redirect_pc & ~32'h3) : granted ? pc_q + INSTR_BYTES : pc_q;
    addr_d = granted ? pc_q : addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      addr_q <= '0;
    end else begin
      pc_q <= pc_d;
      addr_q <= addr_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, discarded_q, discarded_d, stall_q, stall_d;
  logic        drop;
  always_comb begin
    drop = imem_rvalid & ((state_q == DISCARD) | ((state_q == WAIT) & redirect));
    fetched_d = fetched_q + {31'b0, push & ~&fetched_q};
    discarded_d = discarded_q + {31'b0, drop & ~&discarded_q};
    stall_d = stall_q + {31'b0, (state_q == REQ) & ~granted & ~&stall_q};
    perf_fetched = fetched_q;
    perf_discarded = discarded_q;
    perf_stall = stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      discarded_q <= '0;
      stall_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      discarded_q <= discarded_d;
      stall_q <= stall_d;
    end
  end
`endif
endmodule
